// File: rtl/idp_step_sequencer.sv
// -----------------------------------------------------------------------------
// idp_step_sequencer
//
// Purpose:
//   Arbitrates single-cycle step requests from two debounced sources (register
//   write and memory write) into one-cycle write strobes for the integer
//   datapath. Each strobe is followed by a fixed settle window before another
//   grant. Requests arriving while the sequencer is busy are remembered in one
//   pending flag per requester. A request that finds its flag already set is
//   dropped, and the sticky ovf flag is raised. Ties are granted round-robin.
//
// Parameters:
//   SETTLE_CYCLES - idle cycles (1..15) held after every write strobe.
//
// Configuration macro:
//   IDP_STEP_COUNT_EN - when defined, step_cnt counts completed write strobes
//                       (8-bit, wrapping). When undefined, step_cnt is tied to
//                       zero and no counter register exists.
//
// Ports:
//   clock     in   system clock, rising-edge active
//   reset     in   asynchronous active-low reset
//   we_pulse  in   one-cycle register-write step request
//   mem_pulse in   one-cycle memory-write step request
//   ovf_clr   in   synchronous clear of ovf
//   rf_we     out  one-cycle register-file write enable
//   mem_we    out  one-cycle memory write enable
//   busy      out  high whenever the FSM is not IDLE
//   ovf       out  sticky flag: a request was dropped
//   step_cnt  out  [7:0] count of completed write strobes
// -----------------------------------------------------------------------------
module idp_step_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       we_pulse,
   input  logic       mem_pulse,
   input  logic       ovf_clr,
   output logic       rf_we,
   output logic       mem_we,
   output logic       busy,
   output logic       ovf,
   output logic [7:0] step_cnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REG_WR = 2'd1,
      MEM_WR = 2'd2,
      SETTLE = 2'd3
   } state_t;

   // The settle counter is loaded on the write-state edge. It is then
   // decremented once per SETTLE cycle, and the FSM leaves SETTLE when the
   // counter reads zero. Loading SETTLE_CYCLES-1 therefore gives exactly
   // SETTLE_CYCLES cycles in SETTLE.
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   // Requester index 0 = register write, 1 = memory write.
   state_t     state_reg;
   state_t     state_next;
   logic [1:0] pulse;
   logic [1:0] pend_reg;
   logic [1:0] pend_next;
   logic [1:0] grant;
   logic [1:0] drop;
   logic       last_mem_reg;
   logic       last_mem_next;
   logic [3:0] settle_reg;
   logic [3:0] settle_next;
   logic       ovf_reg;
   logic       ovf_next;

   assign pulse = {mem_pulse, we_pulse};

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic and grant decode
   // A grant is only produced on the IDLE -> write-state transition, so the
   // grant vector also marks the edge on which a pending flag is consumed.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      grant      = 2'b00;
      case (state_reg)
         IDLE: begin
            // The register requester wins when it is alone, or on a tie when
            // the memory requester was served last.
            if (pend_reg[0] && (!pend_reg[1] || last_mem_reg)) begin
               state_next = REG_WR;
               grant[0]   = 1'b1;
            end else if (pend_reg[1]) begin
               state_next = MEM_WR;
               grant[1]   = 1'b1;
            end
         end
         REG_WR, MEM_WR: state_next = SETTLE;
         SETTLE: begin
            if (settle_reg == 4'd0) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs, decoded from the state register only
   // ---------------------------------------------------------------------------
   always_comb begin
      rf_we  = 1'b0;
      mem_we = 1'b0;
      busy   = 1'b0;
      case (state_reg)
         IDLE:    busy   = 1'b0;
         REG_WR:  begin rf_we  = 1'b1; busy = 1'b1; end
         MEM_WR:  begin mem_we = 1'b1; busy = 1'b1; end
         SETTLE:  busy   = 1'b1;
         default: busy   = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Pending flags, one per requester.
   // A pulse always leaves its flag set, including on the grant edge, so that
   // back-to-back requests are not lost. A pulse is dropped only when the flag
   // is already set and is not being consumed on this edge.
   // ---------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_req
         assign drop[gi]      = pulse[gi] & pend_reg[gi] & ~grant[gi];
         assign pend_next[gi] = pulse[gi] | (pend_reg[gi] & ~grant[gi]);
      end
   endgenerate

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pend_reg <= 2'b00;
      end else begin
         pend_reg <= pend_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Round-robin history: remembers which requester was granted most recently.
   // It resets to "memory", so the register requester wins the first tie.
   // ---------------------------------------------------------------------------
   always_comb begin
      last_mem_next = last_mem_reg;
      if (grant[1]) begin
         last_mem_next = 1'b1;
      end else if (grant[0]) begin
         last_mem_next = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         last_mem_reg <= 1'b1;
      end else begin
         last_mem_reg <= last_mem_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Settle counter
   // ---------------------------------------------------------------------------
   always_comb begin
      settle_next = settle_reg;
      if (state_reg == REG_WR || state_reg == MEM_WR) begin
         settle_next = SETTLE_LOAD;
      end else if (state_reg == SETTLE && settle_reg != 4'd0) begin
         settle_next = settle_reg - 4'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         settle_reg <= 4'd0;
      end else begin
         settle_reg <= settle_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Sticky overflow flag: a drop on the same edge as a clear takes priority,
   // so the new event is never lost.
   // ---------------------------------------------------------------------------
   always_comb begin
      ovf_next = ovf_reg;
      if (|drop) begin
         ovf_next = 1'b1;
      end else if (ovf_clr) begin
         ovf_next = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ovf_reg <= 1'b0;
      end else begin
         ovf_reg <= ovf_next;
      end
   end

   assign ovf = ovf_reg;

   // ---------------------------------------------------------------------------
   // Completed-strobe counter. It advances on the edge that ends each
   // write-state cycle.
   // ---------------------------------------------------------------------------
`ifdef IDP_STEP_COUNT_EN
   logic [7:0] step_cnt_reg;
   logic [7:0] step_cnt_next;

   always_comb begin
      step_cnt_next = step_cnt_reg;
      if (state_reg == REG_WR || state_reg == MEM_WR) begin
         step_cnt_next = step_cnt_reg + 8'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         step_cnt_reg <= 8'd0;
      end else begin
         step_cnt_reg <= step_cnt_next;
      end
   end

   assign step_cnt = step_cnt_reg;
`else
   assign step_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_idp_step_sequencer.sv
// -----------------------------------------------------------------------------
// tb_idp_step_sequencer
//
// Directed testbench for idp_step_sequencer with SETTLE_CYCLES = 3.
// Inputs change 1 time unit after a rising edge, and outputs are sampled at
// that same point, well away from the active edge.
// Expected step_cnt values follow the IDP_STEP_COUNT_EN setting of the build.
// -----------------------------------------------------------------------------
module tb_idp_step_sequencer;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       we_pulse = 1'b0;
   logic       mem_pulse = 1'b0;
   logic       ovf_clr = 1'b0;
   logic       rf_we;
   logic       mem_we;
   logic       busy;
   logic       ovf;
   logic [7:0] step_cnt;

   int pass_cnt  = 0;
   int check_cnt = 0;
   bit both_seen = 1'b0;

`ifdef IDP_STEP_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   idp_step_sequencer #(.SETTLE_CYCLES(3)) dut (
      .clock     (clock),
      .reset     (reset),
      .we_pulse  (we_pulse),
      .mem_pulse (mem_pulse),
      .ovf_clr   (ovf_clr),
      .rf_we     (rf_we),
      .mem_we    (mem_we),
      .busy      (busy),
      .ovf       (ovf),
      .step_cnt  (step_cnt)
   );

   always #5 clock = ~clock;

   // The two strobes must never be high together.
   always @(negedge clock) begin
      if (rf_we === 1'b1 && mem_we === 1'b1) both_seen = 1'b1;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse(input logic w, input logic m);
      we_pulse  = w;
      mem_pulse = m;
      tick();
      we_pulse  = 1'b0;
      mem_pulse = 1'b0;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      tick();
   endtask

   // Records one sample per cycle (bit i = cycle i, starting now).
   task automatic capture(input int n, output logic [31:0] rf_h,
                          output logic [31:0] mem_h, output logic [31:0] busy_h);
      rf_h   = '0;
      mem_h  = '0;
      busy_h = '0;
      for (int i = 0; i < n; i++) begin
         rf_h[i]   = rf_we;
         mem_h[i]  = mem_we;
         busy_h[i] = busy;
         tick();
      end
   endtask

   task automatic test_reset();
      logic [31:0] rh, mh, bh;
      we_pulse  = 1'b1;
      mem_pulse = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      check_cnt++;
      if ({rf_we, mem_we, busy, ovf, step_cnt} !== 12'h000)
         $display("FAIL reset_outputs: got %b expected %b", {rf_we, mem_we, busy, ovf, step_cnt}, 12'h000);
      else pass_cnt++;
      repeat (3) tick();
      check_cnt++;
      if ({rf_we, mem_we, busy} !== 3'b000)
         $display("FAIL reset_ignores_pulses: got %b expected %b", {rf_we, mem_we, busy}, 3'b000);
      else pass_cnt++;
      // Release with we_pulse still high: the first edge after release honours it.
      reset     = 1'b1;
      mem_pulse = 1'b0;
      tick();
      we_pulse = 1'b0;
      capture(4, rh, mh, bh);
      check_cnt++;
      if (rh[3:0] !== 4'b0010) $display("FAIL first_pulse_rf: got %b expected %b", rh[3:0], 4'b0010);
      else pass_cnt++;
      check_cnt++;
      if (bh[3:0] !== 4'b1110) $display("FAIL first_pulse_busy: got %b expected %b", bh[3:0], 4'b1110);
      else pass_cnt++;
      $display("test_reset done");
   endtask

   task automatic test_single();
      logic [31:0] rh, mh, bh;
      logic [7:0]  exp_cnt;
      apply_reset();
      pulse(1'b1, 1'b0);
      capture(7, rh, mh, bh);
      check_cnt++;
      if (rh[6:0] !== 7'b0000010) $display("FAIL single_rf: got %b expected %b", rh[6:0], 7'b0000010);
      else pass_cnt++;
      check_cnt++;
      if (mh[6:0] !== 7'b0000000) $display("FAIL single_mem: got %b expected %b", mh[6:0], 7'b0000000);
      else pass_cnt++;
      check_cnt++;
      if (bh[6:0] !== 7'b0011110) $display("FAIL single_busy: got %b expected %b", bh[6:0], 7'b0011110);
      else pass_cnt++;
      exp_cnt = CNT_EN ? 8'd1 : 8'd0;
      check_cnt++;
      if (step_cnt !== exp_cnt) $display("FAIL single_step_cnt: got %0d expected %0d", step_cnt, exp_cnt);
      else pass_cnt++;
      $display("test_single done");
   endtask

   task automatic test_round_robin();
      logic [31:0] rh, mh, bh;
      apply_reset();
      // First tie after reset: reg first, then mem.
      pulse(1'b1, 1'b1);
      capture(12, rh, mh, bh);
      check_cnt++;
      if (rh[11:0] !== 12'b000000000010) $display("FAIL tie1_rf: got %b expected %b", rh[11:0], 12'b000000000010);
      else pass_cnt++;
      check_cnt++;
      if (mh[11:0] !== 12'b000001000000) $display("FAIL tie1_mem: got %b expected %b", mh[11:0], 12'b000001000000);
      else pass_cnt++;
      check_cnt++;
      if (bh[11:0] !== 12'b001111011110) $display("FAIL tie1_busy: got %b expected %b", bh[11:0], 12'b001111011110);
      else pass_cnt++;
      // mem served last, so reg wins again.
      pulse(1'b1, 1'b1);
      capture(12, rh, mh, bh);
      check_cnt++;
      if (rh[11:0] !== 12'b000000000010) $display("FAIL tie2_rf: got %b expected %b", rh[11:0], 12'b000000000010);
      else pass_cnt++;
      check_cnt++;
      if (mh[11:0] !== 12'b000001000000) $display("FAIL tie2_mem: got %b expected %b", mh[11:0], 12'b000001000000);
      else pass_cnt++;
      // After a lone reg grant, the next tie goes to mem.
      pulse(1'b1, 1'b0);
      repeat (8) tick();
      pulse(1'b1, 1'b1);
      capture(12, rh, mh, bh);
      check_cnt++;
      if (mh[11:0] !== 12'b000000000010) $display("FAIL tie3_mem: got %b expected %b", mh[11:0], 12'b000000000010);
      else pass_cnt++;
      check_cnt++;
      if (rh[11:0] !== 12'b000001000000) $display("FAIL tie3_rf: got %b expected %b", rh[11:0], 12'b000001000000);
      else pass_cnt++;
      $display("test_round_robin done");
   endtask

   task automatic test_overflow();
      logic [31:0] rh, mh, bh;
      apply_reset();
      pulse(1'b1, 1'b0);
      tick();            // REG_WR
      tick();            // first SETTLE cycle
      pulse(1'b1, 1'b0); // sets reg_pend during SETTLE
      pulse(1'b1, 1'b0); // flag already set: dropped
      check_cnt++;
      if (ovf !== 1'b1) $display("FAIL ovf_set: got %b expected %b", ovf, 1'b1);
      else pass_cnt++;
      capture(8, rh, mh, bh);
      check_cnt++;
      if (rh[7:0] !== 8'b00000100) $display("FAIL ovf_extra_rf: got %b expected %b", rh[7:0], 8'b00000100);
      else pass_cnt++;
      check_cnt++;
      if (bh[7:0] !== 8'b00111101) $display("FAIL ovf_busy: got %b expected %b", bh[7:0], 8'b00111101);
      else pass_cnt++;
      check_cnt++;
      if (ovf !== 1'b1) $display("FAIL ovf_sticky: got %b expected %b", ovf, 1'b1);
      else pass_cnt++;
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check_cnt++;
      if (ovf !== 1'b0) $display("FAIL ovf_clr: got %b expected %b", ovf, 1'b0);
      else pass_cnt++;
      // Clear and a new drop on the same edge: the set wins.
      pulse(1'b1, 1'b0);
      tick();            // REG_WR
      pulse(1'b1, 1'b0); // sets reg_pend, no drop
      check_cnt++;
      if (ovf !== 1'b0) $display("FAIL ovf_no_false_drop: got %b expected %b", ovf, 1'b0);
      else pass_cnt++;
      we_pulse = 1'b1;
      ovf_clr  = 1'b1;
      tick();
      we_pulse = 1'b0;
      ovf_clr  = 1'b0;
      check_cnt++;
      if (ovf !== 1'b1) $display("FAIL ovf_set_beats_clr: got %b expected %b", ovf, 1'b1);
      else pass_cnt++;
      repeat (12) tick();
      $display("test_overflow done");
   endtask

   task automatic test_grant_edge();
      logic [31:0] rh, mh, bh;
      apply_reset();
      we_pulse = 1'b1;
      tick();            // sets reg_pend
      tick();            // grant edge, pulse keeps flag set
      we_pulse = 1'b0;
      check_cnt++;
      if (ovf !== 1'b0) $display("FAIL grant_edge_ovf: got %b expected %b", ovf, 1'b0);
      else pass_cnt++;
      capture(7, rh, mh, bh);
      check_cnt++;
      if (rh[6:0] !== 7'b0100001) $display("FAIL grant_edge_rf: got %b expected %b", rh[6:0], 7'b0100001);
      else pass_cnt++;
      check_cnt++;
      if (bh[6:0] !== 7'b1101111) $display("FAIL grant_edge_busy: got %b expected %b", bh[6:0], 7'b1101111);
      else pass_cnt++;
      repeat (6) tick();
      $display("test_grant_edge done");
   endtask

   task automatic test_wrap();
      int         rf_count;
      int         bad;
      logic [7:0] exp_cnt;
      apply_reset();
      rf_count = 0;
      bad      = 0;
      for (int i = 0; i < 256; i++) begin
         pulse(1'b1, 1'b0);
         for (int j = 0; j < 6; j++) begin
            if (rf_we === 1'b1) rf_count++;
            tick();
         end
         exp_cnt = CNT_EN ? 8'((i + 1) % 256) : 8'd0;
         if (step_cnt !== exp_cnt) bad++;
      end
      check_cnt++;
      if (rf_count != 256) $display("FAIL wrap_strobes: got %0d expected %0d", rf_count, 256);
      else pass_cnt++;
      check_cnt++;
      if (bad != 0) $display("FAIL wrap_step_track: got %0d bad samples expected %0d", bad, 0);
      else pass_cnt++;
      check_cnt++;
      if (step_cnt !== 8'd0) $display("FAIL wrap_to_zero: got %0d expected %0d", step_cnt, 0);
      else pass_cnt++;
      $display("test_wrap done");
   endtask

   task automatic test_reset_mid();
      logic [31:0] rh, mh, bh;
      apply_reset();
      pulse(1'b1, 1'b1);
      tick();            // REG_WR with mem_pend still set
      check_cnt++;
      if (rf_we !== 1'b1) $display("FAIL mid_pre_rf: got %b expected %b", rf_we, 1'b1);
      else pass_cnt++;
      #2;
      reset = 1'b0;
      #1;
      check_cnt++;
      if ({rf_we, mem_we, busy, ovf, step_cnt} !== 12'h000)
         $display("FAIL mid_reset_outputs: got %b expected %b", {rf_we, mem_we, busy, ovf, step_cnt}, 12'h000);
      else pass_cnt++;
      repeat (2) tick();
      reset = 1'b1;
      capture(10, rh, mh, bh);
      check_cnt++;
      if (rh[9:0] !== 10'd0) $display("FAIL mid_no_rf: got %b expected %b", rh[9:0], 10'd0);
      else pass_cnt++;
      check_cnt++;
      if (mh[9:0] !== 10'd0) $display("FAIL mid_no_mem: got %b expected %b", mh[9:0], 10'd0);
      else pass_cnt++;
      check_cnt++;
      if (bh[9:0] !== 10'd0) $display("FAIL mid_no_busy: got %b expected %b", bh[9:0], 10'd0);
      else pass_cnt++;
      $display("test_reset_mid done");
   endtask

   initial begin
      tick();
      test_reset();
      test_single();
      test_round_robin();
      test_overflow();
      test_grant_edge();
      test_wrap();
      test_reset_mid();
      check_cnt++;
      if (both_seen !== 1'b0) $display("FAIL exclusive_strobes: got %b expected %b", both_seen, 1'b0);
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
